// File: rtl/rf_writeback.sv
// rf_writeback: register file write-port controller.
// Merges single-cycle ALU results with variable-latency slow-path results
// into one registered write per cycle. ALU results win; slow results wait in
// a small FIFO. A busy scoreboard tracks registers awaiting a slow result.
// Optional feature macro: RF_WB_FWD_EN (adds look_rd/look_hit/look_data bypass).
`ifndef REG_SIZE
`define REG_SIZE 5
`endif

module rf_writeback #(
   parameter int XLEN       = 32,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  alu_valid,
   input  logic [`REG_SIZE-1:0]  alu_rd,
   input  logic [XLEN-1:0]       alu_data,
   input  logic                  mem_valid,
   output logic                  mem_ready,
   input  logic [`REG_SIZE-1:0]  mem_rd,
   input  logic [XLEN-1:0]       mem_data,
   input  logic                  issue_valid,
   input  logic [`REG_SIZE-1:0]  issue_rd,
   output logic [31:0]           busy_vec,
`ifdef RF_WB_FWD_EN
   input  logic [`REG_SIZE-1:0]  look_rd,
   output logic                  look_hit,
   output logic [XLEN-1:0]       look_data,
`endif
   output logic                  wen_a,
   output logic [`REG_SIZE-1:0]  addr_a,
   output logic [XLEN-1:0]       in_a
);

   localparam int RW    = `REG_SIZE;
   localparam int PTR_W = $clog2(FIFO_DEPTH);

   // Slow-path FIFO storage; pointers carry one extra wrap bit for full/empty.
   logic [RW-1:0]   fifo_rd   [FIFO_DEPTH];
   logic [XLEN-1:0] fifo_data [FIFO_DEPTH];
   logic [PTR_W:0]  wr_ptr, rd_ptr;
   logic            fifo_full, fifo_empty;
   logic            push, pop;
   logic [RW-1:0]   head_rd;
   logic [XLEN-1:0] head_data;

   // Write selection for the current cycle, registered onto the write port.
   logic            alu_sel_p0;
   logic            wr_vld_p0;
   logic [RW-1:0]   wr_rd_p0;
   logic [XLEN-1:0] wr_data_p0;
   logic [31:0]     busy_nxt;

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign mem_ready  = !rst && !fifo_full;
   assign push       = mem_valid && mem_ready;
   assign head_rd    = fifo_rd[rd_ptr[PTR_W-1:0]];
   assign head_data  = fifo_data[rd_ptr[PTR_W-1:0]];

   // Choose between ALU result and FIFO head; rd 0 never produces a write.
   always_comb begin
      alu_sel_p0 = alu_valid && (alu_rd != '0);
      pop        = !alu_sel_p0 && !fifo_empty && !rst;
      wr_vld_p0  = 1'b0;
      wr_rd_p0   = addr_a;
      wr_data_p0 = in_a;
      if (alu_sel_p0) begin
         wr_vld_p0  = 1'b1;
         wr_rd_p0   = alu_rd;
         wr_data_p0 = alu_data;
      end else if (pop && (head_rd != '0)) begin
         wr_vld_p0  = 1'b1;
         wr_rd_p0   = head_rd;
         wr_data_p0 = head_data;
      end
   end

   // Scoreboard update: completion clears, issue sets, set wins on collision.
   always_comb begin
      busy_nxt = busy_vec;
      if (pop)
         busy_nxt[head_rd] = 1'b0;
      if (issue_valid && (issue_rd != '0))
         busy_nxt[issue_rd] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   // FIFO payload storage; contents are meaningless until pointed at.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_rd[wr_ptr[PTR_W-1:0]]   <= mem_rd;
         fifo_data[wr_ptr[PTR_W-1:0]] <= mem_data;
      end
   end

   // FIFO pointers and scoreboard state.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         busy_vec <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
         busy_vec <= busy_nxt;
      end
   end

   // Registered register-file write port; address/data hold when idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         wen_a  <= 1'b0;
         addr_a <= '0;
         in_a   <= '0;
      end else begin
         wen_a  <= wr_vld_p0;
         addr_a <= wr_rd_p0;
         in_a   <= wr_data_p0;
      end
   end

`ifdef RF_WB_FWD_EN
   // Bypass of the write currently on the port, for decode-stage reads.
   always_comb begin
      look_hit  = wen_a && (addr_a == look_rd) && (look_rd != '0);
      look_data = in_a;
   end
`endif

endmodule
